pipe_regs_fde: RTL and testbench
================================

PIPE_REGS_FDE -- requirements
Module: pipe_regs_fde

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PCF value after reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013, instruction word loaded into InstrD on flush/reset.
REQ-003 clk  input  1  rising-edge clock, sole clock of the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 StallF, StallD, FlushD, FlushE  input  1 each  hazard controls from the hazard unit.
REQ-006 PCNextF  input  32  next fetch address selected upstream (PC+4 or branch/jump target).
REQ-007 InstrF, PCPlus4F  input  32 each  fetched instruction and PCF+4.
REQ-008 PCF  output  32  fetch PC register.
REQ-009 InstrD, PCD, PCPlus4D  output  32 each  IF/ID register contents.
REQ-010 Rs1D, Rs2D  output  5 each  InstrD[19:15], InstrD[24:20], combinational from InstrD.
REQ-011 RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  input  1 each  decode control bits.
REQ-012 ResultSrcD  input  2;  ALUControlD  input  3  decode control fields.
REQ-013 RD1D, RD2D, ImmExtD  input  32 each  register-file read data and extended immediate.
REQ-014 *E outputs (RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE[1:0], ALUControlE[2:0], RD1E, RD2E, ImmExtE, PCE, PCPlus4E)  output  same widths as D counterparts  ID/EX register contents.
REQ-015 Rs1E, Rs2E, RdE  output  5 each  registered from Rs1D, Rs2D, InstrD[11:7].
REQ-016 ValidD, ValidE  output  1 each  stage holds a real instruction (0 = bubble).
REQ-017 StallCnt  output  16  saturating count of fetch-stall cycles.

Function
REQ-018 All state SHALL update only on rising clk; priority per register: reset > flush > stall > load.
REQ-019 PCF SHALL load PCNextF each cycle unless StallF=1 and FlushD=0; FlushD overrides StallF so a taken branch/jump coinciding with a load-use stall is not lost.
REQ-020 IF/ID: FlushD=1 -> InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
REQ-021 IF/ID: FlushD=0, StallD=1 -> InstrD, PCD, PCPlus4D, ValidD hold.
REQ-022 IF/ID: FlushD=0, StallD=0 -> InstrD=InstrF, PCD=PCF, PCPlus4D=PCPlus4F, ValidD=1.
REQ-023 ID/EX: FlushE=1 -> every E control bit/field, Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E = 0, ValidE=0.
REQ-024 ID/EX: FlushE=0 -> all E registers load D counterparts, ValidE=ValidD; ID/EX has no stall input.
REQ-025 A flushed ID/EX entry SHALL have RegWriteE=0, MemWriteE=0, JumpE=0, BranchE=0, ResultSrcE=2'b00 so it cannot write state, redirect, or trigger a load-use stall.
REQ-026 StallCnt SHALL increment by 1 on each cycle with StallF=1 and FlushD=0, saturate at 16'hFFFF (no wrap), reset only by reset.
REQ-027 Load-use stall sequence (StallF=StallD=FlushE=1 for one cycle) SHALL hold PCF and IF/ID for exactly one cycle and insert exactly one bubble in ID/EX.
REQ-028 Rs1D/Rs2D SHALL be 0 whenever InstrD=NOP_INSTR (default value guarantees this).

Reset
REQ-029 On reset=1 at a clk edge: PCF=RESET_PC, InstrD=NOP_INSTR, all other D and E registers 0, ValidD=ValidE=0, StallCnt=0, regardless of stall/flush inputs.
REQ-030 Reset asserted mid-stall SHALL discard held state; first cycle after deassertion loads normally.
REQ-031 First edge after reset deasserts with no hazards: PCF=PCNextF, ValidD=1; ValidE=1 one cycle later.

Verification
REQ-032 Reset, then PCNextF=PCF+4 for 3 cycles, no hazards -> PCF 0,4,8,C; InstrD tracks InstrF with 1-cycle lag; RdE tracks InstrD[11:7] with 1 more cycle.
REQ-033 InstrD=lw x5 (RdE becomes 5) then StallF=StallD=FlushE=1 for 1 cycle -> PCF and InstrD unchanged, ValidE=0, RegWriteE=0, StallCnt=1.
REQ-034 FlushD=FlushE=1 with PCNextF=32'h0000_0100 -> next cycle PCF=0x100, InstrD=0x00000013, ValidD=0, ValidE=0, Rs1D=Rs2D=0.
REQ-035 StallF=StallD=1 and FlushD=FlushE=1 same cycle, PCNextF=0x200 -> PCF=0x200, InstrD=NOP, StallCnt unchanged.
REQ-036 Hold StallF=1, FlushD=0 for 70000 cycles -> StallCnt=16'hFFFF and stays; assert reset during stall -> PCF=RESET_PC, StallCnt=0, all Valid=0.

Source files
------------

// File: rtl/pipe_regs_fde.sv
// Fetch PC register plus IF/ID and ID/EX pipeline registers of a five-stage core,
// with stall/flush handling from the hazard unit and a saturating fetch-stall counter.
module pipe_regs_fde #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        FlushE,
    input  logic [31:0] PCNextF,
    input  logic [31:0] InstrF,
    input  logic [31:0] PCPlus4F,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        JumpD,
    input  logic        BranchD,
    input  logic        ALUSrcD,
    input  logic [1:0]  ResultSrcD,
    input  logic [2:0]  ALUControlD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] ImmExtD,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic        ValidD,
    output logic        ValidE,
    output logic [15:0] StallCnt
);

    logic [31:0] pcF_r, instrD_r, pcD_r, pcPlus4D_r;
    logic        validD_r;
    logic [31:0] pcFNext_s, instrDNext_s, pcDNext_s, pcPlus4DNext_s;
    logic        validDNext_s;
    logic [15:0] stallCnt_r, stallCntNext_s;
    logic        fetchStall_s;

    logic        regWriteE_r, memWriteE_r, jumpE_r, branchE_r, aluSrcE_r, validE_r;
    logic [1:0]  resultSrcE_r;
    logic [2:0]  aluControlE_r;
    logic [31:0] rd1E_r, rd2E_r, immExtE_r, pcE_r, pcPlus4E_r;
    logic [4:0]  rs1E_r, rs2E_r, rdE_r;

    logic        regWriteENext_s, memWriteENext_s, jumpENext_s, branchENext_s;
    logic        aluSrcENext_s, validENext_s;
    logic [1:0]  resultSrcENext_s;
    logic [2:0]  aluControlENext_s;
    logic [31:0] rd1ENext_s, rd2ENext_s, immExtENext_s, pcENext_s, pcPlus4ENext_s;
    logic [4:0]  rs1ENext_s, rs2ENext_s, rdENext_s;

    // A redirect (FlushD) wins over a fetch stall so a taken branch is never dropped
    assign fetchStall_s = StallF & ~FlushD;

    // Fetch PC and saturating stall counter next-state
    always_comb begin
        pcFNext_s      = pcF_r;
        stallCntNext_s = stallCnt_r;
        if (fetchStall_s) begin
            pcFNext_s = pcF_r;
            if (stallCnt_r != 16'hFFFF) begin
                stallCntNext_s = stallCnt_r + 16'd1;
            end else begin
                stallCntNext_s = stallCnt_r;
            end
        end else begin
            pcFNext_s      = PCNextF;
            stallCntNext_s = stallCnt_r;
        end
    end

    // IF/ID next-state: flush, then stall, then load
    always_comb begin
        instrDNext_s   = instrD_r;
        pcDNext_s      = pcD_r;
        pcPlus4DNext_s = pcPlus4D_r;
        validDNext_s   = validD_r;
        if (FlushD) begin
            instrDNext_s   = NOP_INSTR;
            pcDNext_s      = 32'h0000_0000;
            pcPlus4DNext_s = 32'h0000_0000;
            validDNext_s   = 1'b0;
        end else if (StallD) begin
            instrDNext_s   = instrD_r;
            pcDNext_s      = pcD_r;
            pcPlus4DNext_s = pcPlus4D_r;
            validDNext_s   = validD_r;
        end else begin
            instrDNext_s   = InstrF;
            pcDNext_s      = pcF_r;
            pcPlus4DNext_s = PCPlus4F;
            validDNext_s   = 1'b1;
        end
    end

    // ID/EX next-state: a flushed entry is all-zero, so it cannot write or redirect
    always_comb begin
        regWriteENext_s   = 1'b0;
        memWriteENext_s   = 1'b0;
        jumpENext_s       = 1'b0;
        branchENext_s     = 1'b0;
        aluSrcENext_s     = 1'b0;
        resultSrcENext_s  = 2'b00;
        aluControlENext_s = 3'b000;
        rd1ENext_s        = 32'h0000_0000;
        rd2ENext_s        = 32'h0000_0000;
        immExtENext_s     = 32'h0000_0000;
        pcENext_s         = 32'h0000_0000;
        pcPlus4ENext_s    = 32'h0000_0000;
        rs1ENext_s        = 5'd0;
        rs2ENext_s        = 5'd0;
        rdENext_s         = 5'd0;
        validENext_s      = 1'b0;
        if (FlushE) begin
            validENext_s = 1'b0;
        end else begin
            regWriteENext_s   = RegWriteD;
            memWriteENext_s   = MemWriteD;
            jumpENext_s       = JumpD;
            branchENext_s     = BranchD;
            aluSrcENext_s     = ALUSrcD;
            resultSrcENext_s  = ResultSrcD;
            aluControlENext_s = ALUControlD;
            rd1ENext_s        = RD1D;
            rd2ENext_s        = RD2D;
            immExtENext_s     = ImmExtD;
            pcENext_s         = pcD_r;
            pcPlus4ENext_s    = pcPlus4D_r;
            rs1ENext_s        = instrD_r[19:15];
            rs2ENext_s        = instrD_r[24:20];
            rdENext_s         = instrD_r[11:7];
            validENext_s      = validD_r;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pcF_r         <= RESET_PC;
            stallCnt_r    <= 16'h0000;
            instrD_r      <= NOP_INSTR;
            pcD_r         <= 32'h0000_0000;
            pcPlus4D_r    <= 32'h0000_0000;
            validD_r      <= 1'b0;
            regWriteE_r   <= 1'b0;
            memWriteE_r   <= 1'b0;
            jumpE_r       <= 1'b0;
            branchE_r     <= 1'b0;
            aluSrcE_r     <= 1'b0;
            resultSrcE_r  <= 2'b00;
            aluControlE_r <= 3'b000;
            rd1E_r        <= 32'h0000_0000;
            rd2E_r        <= 32'h0000_0000;
            immExtE_r     <= 32'h0000_0000;
            pcE_r         <= 32'h0000_0000;
            pcPlus4E_r    <= 32'h0000_0000;
            rs1E_r        <= 5'd0;
            rs2E_r        <= 5'd0;
            rdE_r         <= 5'd0;
            validE_r      <= 1'b0;
        end else begin
            pcF_r         <= pcFNext_s;
            stallCnt_r    <= stallCntNext_s;
            instrD_r      <= instrDNext_s;
            pcD_r         <= pcDNext_s;
            pcPlus4D_r    <= pcPlus4DNext_s;
            validD_r      <= validDNext_s;
            regWriteE_r   <= regWriteENext_s;
            memWriteE_r   <= memWriteENext_s;
            jumpE_r       <= jumpENext_s;
            branchE_r     <= branchENext_s;
            aluSrcE_r     <= aluSrcENext_s;
            resultSrcE_r  <= resultSrcENext_s;
            aluControlE_r <= aluControlENext_s;
            rd1E_r        <= rd1ENext_s;
            rd2E_r        <= rd2ENext_s;
            immExtE_r     <= immExtENext_s;
            pcE_r         <= pcENext_s;
            pcPlus4E_r    <= pcPlus4ENext_s;
            rs1E_r        <= rs1ENext_s;
            rs2E_r        <= rs2ENext_s;
            rdE_r         <= rdENext_s;
            validE_r      <= validENext_s;
        end
    end

    assign PCF         = pcF_r;
    assign StallCnt    = stallCnt_r;
    assign InstrD      = instrD_r;
    assign PCD         = pcD_r;
    assign PCPlus4D    = pcPlus4D_r;
    assign ValidD      = validD_r;
    assign Rs1D        = instrD_r[19:15];
    assign Rs2D        = instrD_r[24:20];
    assign RegWriteE   = regWriteE_r;
    assign MemWriteE   = memWriteE_r;
    assign JumpE       = jumpE_r;
    assign BranchE     = branchE_r;
    assign ALUSrcE     = aluSrcE_r;
    assign ResultSrcE  = resultSrcE_r;
    assign ALUControlE = aluControlE_r;
    assign RD1E        = rd1E_r;
    assign RD2E        = rd2E_r;
    assign ImmExtE     = immExtE_r;
    assign PCE         = pcE_r;
    assign PCPlus4E    = pcPlus4E_r;
    assign Rs1E        = rs1E_r;
    assign Rs2E        = rs2E_r;
    assign RdE         = rdE_r;
    assign ValidE      = validE_r;

endmodule

// File: tb/tb_pipe_regs_fde.sv
// Scoreboard bench for pipe_regs_fde: a pipeline-level reference model predicts the
// register contents after every edge; a monitor compares them on the falling edge.
module tb_pipe_regs_fde;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] LW_X5    = 32'h0000_A283;  // lw x5, 0(x1)

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, StallF, StallD, FlushD, FlushE;
    logic [31:0] PCNextF, InstrF, PCPlus4F, PCF, InstrD, PCD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]  ResultSrcD, ResultSrcE;
    logic [2:0]  ALUControlD, ALUControlE;
    logic [31:0] RD1D, RD2D, ImmExtD, RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidD, ValidE;
    logic [15:0] StallCnt;

    pipe_regs_fde #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .FlushE(FlushE), .PCNextF(PCNextF), .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
        .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidD(ValidD), .ValidE(ValidE),
        .StallCnt(StallCnt)
    );

    // Architectural view of one instruction slot in the execute stage
    typedef struct {
        logic        valid, regWrite, memWrite, jump, branch, aluSrc;
        logic [1:0]  resultSrc;
        logic [2:0]  aluControl;
        logic [31:0] rd1, rd2, imm, pc, pcPlus4;
        logic [4:0]  rs1, rs2, rd;
    } exSlot_t;

    typedef struct {
        logic [31:0] pcF, instrD, pcD, pcPlus4D;
        logic        validD;
        exSlot_t     ex;
        int          stalls;
    } pipe_t;

    pipe_t  m;
    pipe_t  expQ[$];
    pipe_t  monE;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Predict the state after the coming edge from the current inputs
    task automatic modelEdge();
        pipe_t   o = m;
        exSlot_t bubble = '{default: '0};
        if (reset) begin
            m = '{pcF: RESET_PC, instrD: NOP, pcD: 32'd0, pcPlus4D: 32'd0,
                  validD: 1'b0, ex: bubble, stalls: 0};
        end else begin
            if (FlushE) m.ex = bubble;
            else m.ex = '{valid: o.validD, regWrite: RegWriteD, memWrite: MemWriteD,
                          jump: JumpD, branch: BranchD, aluSrc: ALUSrcD,
                          resultSrc: ResultSrcD, aluControl: ALUControlD,
                          rd1: RD1D, rd2: RD2D, imm: ImmExtD, pc: o.pcD,
                          pcPlus4: o.pcPlus4D, rs1: o.instrD[19:15],
                          rs2: o.instrD[24:20], rd: o.instrD[11:7]};
            if (FlushD) begin
                m.instrD = NOP; m.pcD = 32'd0; m.pcPlus4D = 32'd0; m.validD = 1'b0;
            end else if (!StallD) begin
                m.instrD = InstrF; m.pcD = o.pcF; m.pcPlus4D = PCPlus4F; m.validD = 1'b1;
            end
            if (StallF && !FlushD) m.stalls = (o.stalls < 65535) ? o.stalls + 1 : 65535;
            else m.pcF = PCNextF;
        end
        expQ.push_back(m);
    endtask

    // Monitor: every falling edge the DUT presents a full register snapshot
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            chk("PCF", PCF, monE.pcF);
            chk("InstrD", InstrD, monE.instrD);
            chk("PCD", PCD, monE.pcD);
            chk("PCPlus4D", PCPlus4D, monE.pcPlus4D);
            chk("ValidD", {31'd0, ValidD}, {31'd0, monE.validD});
            chk("Rs1D", {27'd0, Rs1D}, {27'd0, monE.instrD[19:15]});
            chk("Rs2D", {27'd0, Rs2D}, {27'd0, monE.instrD[24:20]});
            chk("StallCnt", {16'd0, StallCnt}, monE.stalls);
            chk("ValidE", {31'd0, ValidE}, {31'd0, monE.ex.valid});
            chk("CtrlE", {23'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE},
                {23'd0, monE.ex.regWrite, monE.ex.memWrite, monE.ex.jump, monE.ex.branch,
                 monE.ex.aluSrc, monE.ex.resultSrc, monE.ex.aluControl});
            chk("RD1E", RD1E, monE.ex.rd1);
            chk("RD2E", RD2E, monE.ex.rd2);
            chk("ImmExtE", ImmExtE, monE.ex.imm);
            chk("PCE", PCE, monE.ex.pc);
            chk("PCPlus4E", PCPlus4E, monE.ex.pcPlus4);
            chk("RegsE", {17'd0, Rs1E, Rs2E, RdE}, {17'd0, monE.ex.rs1, monE.ex.rs2, monE.ex.rd});
        end
    end

    task automatic hz(input logic r, input logic sf, input logic sd, input logic fd, input logic fe);
        reset = r; StallF = sf; StallD = sd; FlushD = fd; FlushE = fe;
    endtask

    task automatic randData();
        {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD} = 5'($urandom);
        ResultSrcD = 2'($urandom); ALUControlD = 3'($urandom);
        RD1D = $urandom; RD2D = $urandom; ImmExtD = $urandom;
        InstrF = $urandom;
        PCNextF = m.pcF + 32'd4;
        PCPlus4F = m.pcF + 32'd4;
    endtask

    task automatic cycle();
        modelEdge();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [31:0] heldPC, heldInstr;
    int          cntBefore;

    initial begin
        hz(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        randData();
        @(negedge clk);
        #1;
        cycle();
        hz(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        randData();
        cycle();
        chk("rst_PCF", PCF, RESET_PC);
        chk("rst_InstrD", InstrD, NOP);
        chk("rst_Valid", {30'd0, ValidD, ValidE}, 32'd0);
        chk("rst_StallCnt", {16'd0, StallCnt}, 32'd0);

        // Straight-line fetch: PCF 0 -> 4 -> 8 -> C
        for (int i = 1; i <= 3; i++) begin
            hz(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            randData();
            cycle();
            chk("seq_PCF", PCF, 32'(i * 4));
            chk("seq_ValidD", {31'd0, ValidD}, 32'd1);
        end
        chk("seq_ValidE", {31'd0, ValidE}, 32'd1);

        // Load-use: lw x5 reaches E, then one stall cycle
        randData(); InstrF = LW_X5;
        cycle();
        randData(); RegWriteD = 1'b1; ResultSrcD = 2'b01;
        cycle();
        chk("lw_RdE", {27'd0, RdE}, 32'd5);
        heldPC = PCF; heldInstr = InstrD;
        hz(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        randData();
        cycle();
        chk("lu_PCF_hold", PCF, heldPC);
        chk("lu_InstrD_hold", InstrD, heldInstr);
        chk("lu_bubble", {30'd0, ValidE, RegWriteE}, 32'd0);
        chk("lu_StallCnt", {16'd0, StallCnt}, 32'd1);

        // Branch redirect flushes D and E
        hz(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        randData(); PCNextF = 32'h0000_0100;
        cycle();
        chk("fl_PCF", PCF, 32'h0000_0100);
        chk("fl_InstrD", InstrD, NOP);
        chk("fl_Valid", {30'd0, ValidD, ValidE}, 32'd0);
        chk("fl_Rs", {22'd0, Rs1D, Rs2D}, 32'd0);

        // Flush coinciding with a stall: redirect wins, counter untouched
        hz(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        randData(); PCNextF = 32'h0000_0200;
        cycle();
        chk("fs_PCF", PCF, 32'h0000_0200);
        chk("fs_InstrD", InstrD, NOP);
        chk("fs_StallCnt", {16'd0, StallCnt}, 32'd1);

        // Random hazard mix
        for (int i = 0; i < 400; i++) begin
            hz(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 4) == 0));
            randData();
            if ($urandom_range(0, 1) == 1) PCNextF = {$urandom} & 32'hFFFF_FFFC;
            cycle();
        end

        // Long fetch stall saturates the counter, then reset mid-stall
        hz(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        randData();
        cycle();
        for (int i = 0; i < 70000; i++) begin
            hz(1'b0, 1'b1, 1'($urandom), 1'b0, 1'($urandom));
            randData();
            cycle();
        end
        chk("sat_StallCnt", {16'd0, StallCnt}, 32'h0000_FFFF);
        hz(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        randData();
        cycle();
        chk("rs_PCF", PCF, RESET_PC);
        chk("rs_StallCnt", {16'd0, StallCnt}, 32'd0);
        chk("rs_Valid", {30'd0, ValidD, ValidE}, 32'd0);
        hz(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        randData(); PCNextF = 32'h0000_0040;
        cycle();
        chk("post_PCF", PCF, 32'h0000_0040);
        chk("post_ValidD", {31'd0, ValidD}, 32'd1);
        randData();
        cycle();
        chk("post_ValidE", {31'd0, ValidE}, 32'd1);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", expQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
